// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem read, 2-entry {instr, pc} queue to decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
//
// state   | meaning
// --------+------------------------------------------
// S_IDLE  | no read outstanding
// S_REQ   | read outstanding, ack will be pushed
// S_DRAIN | read outstanding, ack will be discarded
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00400020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;

    logic        v0_q, v1_q;
    logic [31:0] instr0_q, pc0_q;
    logic [31:0] instr1_q, pc1_q;

    logic [1:0]  count;
    logic [2:0]  count_nxt;
    logic        push, pop, room, issue;

    assign count     = {1'b0, v0_q} + {1'b0, v1_q};
    assign pop       = v0_q & id_ready;
    assign push      = (state_q == S_REQ) & imem_ack & ~flush;
    // pop implies count >= 1, so this never underflows
    assign count_nxt = {1'b0, count} - {2'b00, pop} + {2'b00, push};
    assign room      = (count_nxt <= 3'd1);
    assign issue     = ((state_q == S_IDLE) | ((state_q == S_REQ) & imem_ack)) & room & ~flush;

    assign pc_advance = issue;
    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign id_valid   = v0_q;
    assign id_instr   = instr0_q;
    assign id_pc      = pc0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        imem_addr_q <= pc_in;
                        imem_req_q  <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (issue) begin
                        imem_addr_q <= pc_in;
                    end else if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (flush) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    imem_req_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Entry 0 is the head and drives id_* directly from its registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            instr0_q <= 32'h0;
            pc0_q    <= RESET_PC;
            instr1_q <= 32'h0;
            pc1_q    <= RESET_PC;
        end else if (flush) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (v1_q) begin
                        instr0_q <= instr1_q;
                        pc0_q    <= pc1_q;
                        instr1_q <= imem_rdata;
                        pc1_q    <= imem_addr_q;
                    end else begin
                        instr0_q <= imem_rdata;
                        pc0_q    <= imem_addr_q;
                    end
                end
                2'b10: begin
                    if (v0_q) begin
                        instr1_q <= imem_rdata;
                        pc1_q    <= imem_addr_q;
                        v1_q     <= 1'b1;
                    end else begin
                        instr0_q <= imem_rdata;
                        pc0_q    <= imem_addr_q;
                        v0_q     <= 1'b1;
                    end
                end
                2'b01: begin
                    if (v1_q) begin
                        instr0_q <= instr1_q;
                        pc0_q    <= pc1_q;
                    end
                    v0_q <= v1_q;
                    v1_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'h0;
            perf_stall_q   <= 32'h0;
        end else begin
            if (push)
                perf_fetched_q <= perf_fetched_q + 32'd1;
            if (id_ready & ~v0_q)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: queue-based reference model plus directed stream,
// latency, backpressure, flush and mid-request reset scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h00400020;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_in      (pc_in),
        .pc_advance (pc_advance),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_ready   (id_ready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v)
            n_pass++;
        else
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp_v, $time);
    endtask

    // Reference model: decode queue, outstanding-read bookkeeping and the PC register.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic        m_req;
    logic        m_drain;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic [31:0] tgt_pc;
    int          w;
    logic        last_valid;
    logic [31:0] last_pc;

    task automatic model_reset(input logic [31:0] pc);
        mq.delete();
        m_req   = 1'b0;
        m_drain = 1'b0;
        m_addr  = RESET_PC;
        m_pc    = pc;
        w       = 0;
    endtask

    task automatic chk_reset();
        chk("rst_imem_req",  imem_req,  32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_id_valid",  id_valid,  32'h0);
        chk("rst_id_pc",     id_pc,     RESET_PC);
        chk("rst_id_instr",  id_instr,  32'h0);
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model at the edge.
    // lat < 0 selects a random ack each cycle; otherwise ack comes after lat wait cycles.
    task automatic step(input int lat, input int rdy_pct, input int fl_pct);
        logic        fl, ak, rd, pop, push, can, issue, room;
        logic [31:0] rdat;
        int          sz;
        fl   = int'($urandom_range(99)) < fl_pct;
        rd   = int'($urandom_range(99)) < rdy_pct;
        if (lat < 0)
            ak = m_req && ($urandom_range(1) == 1);
        else
            ak = m_req && (w >= lat);
        rdat = $urandom;
        if (fl_pct < 100)
            tgt_pc = $urandom & 32'hFFFF_FFFC;

        flush      = fl;
        imem_ack   = ak;
        id_ready   = rd;
        imem_rdata = rdat;
        pc_in      = m_pc;

        sz    = mq.size();
        pop   = (sz > 0) && rd;
        push  = m_req && !m_drain && ak && !fl;
        room  = (sz - int'(pop) + int'(push)) <= 1;
        can   = !m_req || (!m_drain && ak);
        issue = can && room && !fl;

        #2;
        chk("pc_advance", pc_advance, issue);
        chk("imem_req",   imem_req,   m_req);
        chk("imem_addr",  imem_addr,  m_addr);
        chk("id_valid",   id_valid,   sz > 0);
        if (sz > 0) begin
            chk("id_pc",    id_pc,    mq[0].pc);
            chk("id_instr", id_instr, mq[0].instr);
        end
        last_valid = id_valid;
        last_pc    = id_pc;

        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (pop)
                void'(mq.pop_front());
            if (push)
                mq.push_back('{instr: rdat, pc: m_addr});
        end
        if (issue) begin
            m_req   = 1'b1;
            m_drain = 1'b0;
            m_addr  = m_pc;
            w       = 0;
        end else if (m_req && ak) begin
            m_req   = 1'b0;
            m_drain = 1'b0;
            w       = 0;
        end else if (m_req) begin
            if (fl)
                m_drain = 1'b1;
            w++;
        end
        if (fl)
            m_pc = tgt_pc;
        else if (issue)
            m_pc = m_pc + 32'd4;
        #1;
    endtask

    initial begin
        int   first;
        logic found;

        rst_n      = 1'b0;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        id_ready   = 1'b0;
        imem_rdata = 32'h0;
        pc_in      = RESET_PC;
        tgt_pc     = RESET_PC;
        last_valid = 1'b0;
        last_pc    = 32'h0;
        model_reset(RESET_PC);

        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;

        // zero-wait stream from reset
        first = -1;
        for (int i = 0; i < 12; i++) begin
            step(0, 100, 0);
            if (last_valid && first < 0) begin
                first = i;
                chk("first_id_pc", last_pc, RESET_PC);
            end
        end
        chk("first_valid_cycle", first, 32'd2);

        // latency 3
        repeat (24) step(3, 100, 0);

        // backpressure then release
        repeat (8) step(0, 0, 0);
        repeat (12) step(0, 100, 0);

        // flush with a read outstanding at latency 3
        for (int i = 0; i < 10 && !(m_req && !m_drain && w == 1); i++)
            step(3, 100, 0);
        tgt_pc = 32'h00400100;
        step(3, 100, 100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(3, 100, 0);
            if (last_valid) begin
                chk("flush_target_pc", last_pc, 32'h00400100);
                found = 1'b1;
                break;
            end
        end
        chk("flush_target_seen", found, 32'h1);

        // flush coinciding with ack and consume
        repeat (5) step(0, 100, 0);
        tgt_pc = 32'h00400200;
        step(0, 100, 100);
        step(0, 100, 0);
        chk("valid_after_ack_flush", last_valid, 32'h0);

        // randomized mixes
        repeat (400) step(-1, 70, 5);
        for (int k = 0; k < 6; k++) begin
            int l;
            l = int'($urandom_range(4));
            repeat (60) step(l, 75, 6);
        end

        // reset mid-request
        for (int i = 0; i < 10 && !(m_req && !m_drain && w == 1); i++)
            step(3, 100, 0);
        #2;
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        flush    = 1'b0;
        #1;
        chk_reset();
        repeat (2) @(posedge clk);
        model_reset(32'h00400300);
        pc_in = m_pc;
        #1;
        rst_n = 1'b1;
        step(0, 100, 0);
        chk("post_reset_req",  imem_req,  32'h1);
        chk("post_reset_addr", imem_addr, 32'h00400300);
        repeat (30) step(1, 80, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly downstream of the PC register. Each fetch captures the current PC, issues a single-outstanding read to instruction memory over a req/ack handshake and buffers returned words in a 2-entry queue feeding decode. It drives `pc_advance` so the next-PC mux steps the PC only when a fetch is actually issued. It also handles redirect flushes, including discarding a read already in flight.

## Interface
- `RESET_PC`, 32'h00400020: value presented on `imem_addr` and `id_pc` while in reset.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_in` in 32: current PC from the PC register.
- `pc_advance` out 1: combinational; next-PC mux selects `pc_in+4` at this edge.
- `flush` in 1: redirect pulse; the next-PC mux loads the target this edge, with priority over `pc_advance`.
- `imem_req` out 1: registered read request.
- `imem_addr` out 32: registered word address, stable while `imem_req` is high.
- `imem_ack` in 1: read done; `imem_rdata` is valid only in this cycle. May be asserted in the first cycle `imem_req` is high.
- `imem_rdata` in 32: instruction word.
- `id_valid` out 1: queue head valid.
- `id_instr` out 32: queue-head instruction.
- `id_pc` out 32: queue-head address.
- `id_ready` in 1: decode consumes the head when `id_valid && id_ready`.

## Operation
- Queue: 2 entries of {instr, pc}, with `count` in the range 0..2.
  - Push on an accepted ack; pop on consume.
  - Push and pop in the same cycle are both honoured.
- States:
  - IDLE: no read outstanding.
  - REQ: read outstanding.
  - DRAIN: outstanding read to be discarded.
- `room`: true when `count - pop + push <= 1`, evaluated this cycle.
- Issue condition: (IDLE, or REQ with `imem_ack`) AND `room` AND `!flush`.
  - On issue, `pc_advance`=1.
  - At the edge: `imem_addr<=pc_in`, `imem_req<=1`, state goes to REQ.
- REQ with ack and no issue: `imem_req<=0`, state goes to IDLE.
- REQ without ack: hold `imem_req` and `imem_addr`.
- Flush (any state):
  - Queue is cleared and `id_valid` becomes 0 next cycle.
  - Any ack arriving in the flush cycle is discarded, not pushed.
  - No issue in the flush cycle.
  - REQ without ack goes to DRAIN with `imem_req` held; otherwise the state goes to IDLE.
- DRAIN: the ack is discarded and `imem_req<=0`, state goes to IDLE. A flush in DRAIN stays in DRAIN.
- Overflow is impossible: at most 1 read is outstanding, and an issue requires `room`.
- Reset values:
  - state IDLE.
  - `imem_req`=0.
  - `imem_addr`=`RESET_PC`.
  - `count`=0 and `id_valid`=0.
  - `id_pc`=`RESET_PC`.
  - `id_instr`=0.
- Reset asserted mid-request abandons the read; instruction memory must tolerate `imem_req` dropping.

## Timing
- Zero-wait memory: from issue edge to `id_valid`, 2 cycles. Sustained throughput is 1 instr/cycle.
- Memory with N-cycle ack latency: throughput is 1 instr per N+1 cycles.
- `pc_advance` depends combinationally on `imem_ack`, `id_ready` and `flush`. There is no path from `imem_rdata`.
- `id_*` outputs are registered from queue storage; there is no combinational bypass from `imem_rdata`.

## Configuration
- Macro `FETCH_PERF_CNT_EN`.
  - Defined: adds outputs `perf_fetched` (32) and `perf_stall` (32), both reset to 0 and wrapping at 2^32.
    - `perf_fetched` increments on every push.
    - `perf_stall` increments every cycle with `id_ready && !id_valid`.
  - Undefined: the ports and logic are absent; all other behaviour is identical.

## Test plan
- Zero-wait stream: ack whenever `imem_req` is high, with `pc_in` following `pc_advance` from 0x00400020.
  - `id_pc` must be 0x00400020, 0x00400024, 0x00400028… on consecutive cycles.
  - `id_valid` first rises 2 cycles after reset release.
- Latency 3: `id_valid` must be high 1 cycle in 4.
  - `imem_addr` must stay constant while `imem_req` is high.
- Backpressure: hold `id_ready`=0 with zero-wait memory.
  - Exactly 2 entries fill, then `pc_advance`=0 and `imem_req`=0.
  - After `id_ready` returns to 1, order is preserved with no loss or duplication.
- Flush with a read outstanding at latency 3, with `pc_in` redirected to 0x00400100.
  - The stale ack is discarded.
  - The next `id_pc` is 0x00400100.
- Flush in the same cycle as an ack and `id_ready`: nothing is pushed, no issue occurs, and `id_valid`=0 next cycle.
- Assert `rst_n`=0 mid-REQ: outputs take their reset values immediately.
  - On release, the first fetch address is the current `pc_in`.
